// File: rtl/axis_pattern_gen_pkg.sv
// Shared definitions for the AXI-Stream pattern generator: register map,
// CONTROL bit positions, FSM state encoding and the run-configuration record.
package axis_pattern_gen_pkg;

    localparam logic [7:0] ADDR_CTRL        = 8'h00;
    localparam logic [7:0] ADDR_BEAT_COUNT  = 8'h10;
    localparam logic [7:0] ADDR_GAP         = 8'h14;
    localparam logic [7:0] ADDR_START_VALUE = 8'h18;
    localparam logic [7:0] ADDR_INCREMENT   = 8'h1C;
    localparam logic [7:0] ADDR_SENT        = 8'h20;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_STOP_BIT  = 1;
    localparam int CTRL_CLEAR_BIT = 2;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } pg_state_e;

    // Host-programmable run parameters as held in the register file.
    typedef struct packed {
        logic [31:0] beat_count;
        logic [31:0] gap;
        logic [31:0] start_value;
        logic [31:0] increment;
    } pg_cfg_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Byte-lane merge of a 32-bit register write.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_pattern_gen_axil_regs_slave.sv
// AXI4-Lite slave: AW/W/B and AR/R handshakes plus the read/write
// configuration registers. CONTROL and SENT belong to the generator core,
// so writes are also exported as a one-cycle strobe and reads of addresses
// not held here fall through to rd_data_i.
module axil_regs_slave
    import axis_pattern_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [1:0]            bresp_o,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [31:0]           rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic                  wr_en_o,
    output logic [7:0]            wr_addr_o,
    output logic [31:0]           wr_data_o,
    output logic [3:0]            wr_strb_o,
    output pg_cfg_t               cfg_o,
    output logic [7:0]            rd_addr_o,
    input  logic [31:0]           rd_data_i
);

    logic        aw_full_q;
    logic [7:0]  awaddr_q;
    logic        bvalid_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    pg_cfg_t     cfg_q;
    logic        aw_fire, w_fire, ar_fire;
    logic [31:0] rd_mux;
    logic        unused_addr_hi;

    // Only the low address byte is decoded.
    assign unused_addr_hi = ^{awaddr_i[ADDR_WIDTH-1:8], araddr_i[ADDR_WIDTH-1:8]};

    // One write in flight: the address latch blocks a new AW until B is accepted.
    assign awready_o = !aw_full_q && !bvalid_q;
    assign wready_o  =  aw_full_q && !bvalid_q;
    assign aw_fire   = awvalid_i && awready_o;
    assign w_fire    = wvalid_i && wready_o;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = 2'b00;

    assign wr_en_o   = w_fire;
    assign wr_addr_o = awaddr_q;
    assign wr_data_o = wdata_i;
    assign wr_strb_o = wstrb_i;
    assign cfg_o     = cfg_q;

    assign arready_o = !rvalid_q;
    assign ar_fire   = arvalid_i && !rvalid_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = 2'b00;
    assign rd_addr_o = araddr_i[7:0];

    // Write address latch and write response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_full_q <= 1'b0;
            awaddr_q  <= 8'h00;
            bvalid_q  <= 1'b0;
        end else begin
            if (aw_fire) begin
                aw_full_q <= 1'b1;
                awaddr_q  <= awaddr_i[7:0];
            end
            if (w_fire) begin
                aw_full_q <= 1'b0;
                bvalid_q  <= 1'b1;
            end else if (bvalid_q && bready_i) begin
                bvalid_q  <= 1'b0;
            end
        end
    end

    // Configuration registers, byte-enabled writes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_q.beat_count  <= 32'd0;
            cfg_q.gap         <= 32'd0;
            cfg_q.start_value <= 32'd0;
            cfg_q.increment   <= 32'd1;
        end else if (w_fire) begin
            case (awaddr_q)
                ADDR_BEAT_COUNT:  cfg_q.beat_count  <= strb_merge(cfg_q.beat_count,  wdata_i, wstrb_i);
                ADDR_GAP:         cfg_q.gap         <= strb_merge(cfg_q.gap,         wdata_i, wstrb_i);
                ADDR_START_VALUE: cfg_q.start_value <= strb_merge(cfg_q.start_value, wdata_i, wstrb_i);
                ADDR_INCREMENT:   cfg_q.increment   <= strb_merge(cfg_q.increment,   wdata_i, wstrb_i);
                default: ;
            endcase
        end
    end

    // Read mux: local registers first, everything else from the core.
    always_comb begin
        rd_mux = rd_data_i;
        case (araddr_i[7:0])
            ADDR_BEAT_COUNT:  rd_mux = cfg_q.beat_count;
            ADDR_GAP:         rd_mux = cfg_q.gap;
            ADDR_START_VALUE: rd_mux = cfg_q.start_value;
            ADDR_INCREMENT:   rd_mux = cfg_q.increment;
            default: ;
        endcase
    end

    // Read response, data held until rready.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else if (ar_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_mux;
        end else if (rvalid_q && rready_i) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_pattern_gen.sv
// AXI-Stream arithmetic-sequence source with an optional idle gap between
// beats, configured and started through an AXI4-Lite control slave.
module axis_pattern_gen
    import axis_pattern_gen_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic [ADDR_WIDTH-1:0]   s_axi_control_awaddr,
    input  logic                    s_axi_control_awvalid,
    output logic                    s_axi_control_awready,
    input  logic [31:0]             s_axi_control_wdata,
    input  logic [3:0]              s_axi_control_wstrb,
    input  logic                    s_axi_control_wvalid,
    output logic                    s_axi_control_wready,
    output logic [1:0]              s_axi_control_bresp,
    output logic                    s_axi_control_bvalid,
    input  logic                    s_axi_control_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_control_araddr,
    input  logic                    s_axi_control_arvalid,
    output logic                    s_axi_control_arready,
    output logic [31:0]             s_axi_control_rdata,
    output logic [1:0]              s_axi_control_rresp,
    output logic                    s_axi_control_rvalid,
    input  logic                    s_axi_control_rready,
    output logic [DATA_BYTES*8-1:0] outstream_tdata,
    output logic                    outstream_tvalid,
    input  logic                    outstream_tready
);

    localparam int DW = DATA_BYTES * 8;

    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    pg_cfg_t     cfg;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;

    pg_state_e   state_q;
    logic        tvalid_q;
    logic [DW-1:0] tdata_q;
    logic [DW-1:0] inc_q;
    logic [31:0] beats_q, gap_q, gap_cnt_q, sent_q;
    logic        stop_pend_q;

    logic        ctrl_wr, start, stop, clear;
    logic        busy, done;
    logic [31:0] sent_nxt;
    logic        unused_wr;

    axil_regs_slave #(.ADDR_WIDTH(ADDR_WIDTH)) u_regs (
        .clk_i     (ap_clk),
        .rst_i     (ap_rst),
        .awaddr_i  (s_axi_control_awaddr),
        .awvalid_i (s_axi_control_awvalid),
        .awready_o (s_axi_control_awready),
        .wdata_i   (s_axi_control_wdata),
        .wstrb_i   (s_axi_control_wstrb),
        .wvalid_i  (s_axi_control_wvalid),
        .wready_o  (s_axi_control_wready),
        .bresp_o   (s_axi_control_bresp),
        .bvalid_o  (s_axi_control_bvalid),
        .bready_i  (s_axi_control_bready),
        .araddr_i  (s_axi_control_araddr),
        .arvalid_i (s_axi_control_arvalid),
        .arready_o (s_axi_control_arready),
        .rdata_o   (s_axi_control_rdata),
        .rresp_o   (s_axi_control_rresp),
        .rvalid_o  (s_axi_control_rvalid),
        .rready_i  (s_axi_control_rready),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data),
        .wr_strb_o (wr_strb),
        .cfg_o     (cfg),
        .rd_addr_o (rd_addr),
        .rd_data_i (rd_data)
    );

    // CONTROL actions need byte lane 0 enabled.
    assign ctrl_wr   = wr_en && (wr_addr == ADDR_CTRL) && wr_strb[0];
    assign start     = ctrl_wr && wr_data[CTRL_START_BIT];
    assign stop      = ctrl_wr && wr_data[CTRL_STOP_BIT];
    assign clear     = ctrl_wr && wr_data[CTRL_CLEAR_BIT];
    assign unused_wr = ^{wr_data[31:3], wr_strb[3:1]};

    assign busy      = (state_q == ST_RUN) || (state_q == ST_GAP);
    assign done      = (state_q == ST_DONE);
    assign sent_nxt  = sat_inc32(sent_q);

    assign outstream_tvalid = tvalid_q;
    assign outstream_tdata  = tdata_q;

    // Core-owned read values; unmapped addresses read as zero.
    always_comb begin
        rd_data = 32'd0;
        if (rd_addr == ADDR_CTRL) begin
            rd_data[STAT_BUSY_BIT] = busy;
            rd_data[STAT_DONE_BIT] = done;
        end else if (rd_addr == ADDR_SENT) begin
            rd_data = sent_q;
        end
    end

    // Sequencer: run parameters are snapshotted at START so host writes
    // mid-run only shape the next run. tvalid is only dropped after a
    // handshake; a STOP that arrives during a stall waits in stop_pend_q.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= ST_IDLE;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            inc_q       <= '0;
            beats_q     <= 32'd0;
            gap_q       <= 32'd0;
            gap_cnt_q   <= 32'd0;
            sent_q      <= 32'd0;
            stop_pend_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        beats_q     <= cfg.beat_count;
                        gap_q       <= cfg.gap;
                        inc_q       <= DW'(cfg.increment);
                        tdata_q     <= DW'(cfg.start_value);
                        sent_q      <= 32'd0;
                        stop_pend_q <= 1'b0;
                        tvalid_q    <= 1'b1;
                        state_q     <= ST_RUN;
                    end else if (clear) begin
                        sent_q      <= 32'd0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (outstream_tready) begin
                        sent_q  <= sent_nxt;
                        tdata_q <= tdata_q + inc_q;
                        if (stop_pend_q || stop || (beats_q != 32'd0 && sent_nxt == beats_q)) begin
                            tvalid_q    <= 1'b0;
                            stop_pend_q <= 1'b0;
                            state_q     <= ST_DONE;
                        end else if (gap_q != 32'd0) begin
                            tvalid_q  <= 1'b0;
                            gap_cnt_q <= gap_q;
                            state_q   <= ST_GAP;
                        end
                    end else if (stop) begin
                        stop_pend_q <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (stop) begin
                        state_q <= ST_DONE;
                    end else if (gap_cnt_q == 32'd1) begin
                        tvalid_q <= 1'b1;
                        state_q  <= ST_RUN;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 32'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Directed bench for axis_pattern_gen: AXI-Lite config, stream sequences,
// gaps, stalls, STOP/CLEAR handling, wrap and reset.
module tb_axis_pattern_gen;

    localparam int DB = 4;
    localparam int AW = 32;
    localparam int DW = DB * 8;

    localparam logic [7:0] A_CTRL = 8'h00;
    localparam logic [7:0] A_BC   = 8'h10;
    localparam logic [7:0] A_GAP  = 8'h14;
    localparam logic [7:0] A_SV   = 8'h18;
    localparam logic [7:0] A_INC  = 8'h1C;
    localparam logic [7:0] A_SENT = 8'h20;

    logic          ap_clk, ap_rst;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] tdata;
    logic          tvalid, tready;

    int n_vec  = 0;
    int n_miss = 0;

    axis_pattern_gen #(.DATA_BYTES(DB), .ADDR_WIDTH(AW)) dut (
        .ap_clk                (ap_clk),
        .ap_rst                (ap_rst),
        .s_axi_control_awaddr  (awaddr),
        .s_axi_control_awvalid (awvalid),
        .s_axi_control_awready (awready),
        .s_axi_control_wdata   (wdata),
        .s_axi_control_wstrb   (wstrb),
        .s_axi_control_wvalid  (wvalid),
        .s_axi_control_wready  (wready),
        .s_axi_control_bresp   (bresp),
        .s_axi_control_bvalid  (bvalid),
        .s_axi_control_bready  (bready),
        .s_axi_control_araddr  (araddr),
        .s_axi_control_arvalid (arvalid),
        .s_axi_control_arready (arready),
        .s_axi_control_rdata   (rdata),
        .s_axi_control_rresp   (rresp),
        .s_axi_control_rvalid  (rvalid),
        .s_axi_control_rready  (rready),
        .outstream_tdata       (tdata),
        .outstream_tvalid      (tvalid),
        .outstream_tready      (tready)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Stream monitor: every handshake with the cycle it happened on.
    logic [DW-1:0] q_data[$];
    int            q_cyc[$];
    int            cyc = 0;
    always @(posedge ap_clk) begin
        if (!ap_rst && tvalid && tready) begin
            q_data.push_back(tdata);
            q_cyc.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge ap_clk);
    endtask

    task automatic clrq();
        q_data.delete();
        q_cyc.delete();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
        int   t;
        logic awf, wf;
        awaddr = {24'h0, a}; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        t = 0;
        while ((awvalid || wvalid) && t < 20) begin
            awf = awvalid && awready;
            wf  = wvalid && wready;
            @(negedge ap_clk);
            if (awf) awvalid = 1'b0;
            if (wf)  wvalid  = 1'b0;
            t++;
        end
        while (!bvalid && t < 20) begin
            @(negedge ap_clk);
            t++;
        end
        if (t >= 20) chk("axil_wr_timeout", 64'(t), 64'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge ap_clk);
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        int   t;
        logic f;
        araddr = {24'h0, a}; arvalid = 1'b1;
        t = 0;
        while (arvalid && t < 20) begin
            f = arready;
            @(negedge ap_clk);
            if (f) arvalid = 1'b0;
            t++;
        end
        while (!rvalid && t < 20) begin
            @(negedge ap_clk);
            t++;
        end
        if (t >= 20) chk("axil_rd_timeout", 64'(t), 64'd0);
        arvalid = 1'b0;
        d = rdata;
        @(negedge ap_clk);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        chk(tag, 64'(v), 64'(exp));
    endtask

    task automatic wait_beats(input int n, input int maxc);
        int t = 0;
        while (q_data.size() < n && t < maxc) begin
            @(negedge ap_clk);
            t++;
        end
    endtask

    initial begin
        int ok, n0;
        ap_rst = 1'b1; tready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b1;
        tick(3);
        ap_rst = 1'b0;
        tick(1);

        // reset state
        chk("rst_tvalid",  64'(tvalid),  64'd0);
        chk("rst_tdata",   64'(tdata),   64'd0);
        chk("rst_bvalid",  64'(bvalid),  64'd0);
        chk("rst_rvalid",  64'(rvalid),  64'd0);
        chk("rst_rdata",   64'(rdata),   64'd0);
        chk("rst_awready", 64'(awready), 64'd1);
        chk("rst_arready", 64'(arready), 64'd1);
        rd_chk("rst_inc",  A_INC,  32'd1);
        rd_chk("rst_bc",   A_BC,   32'd0);
        rd_chk("rst_ctrl", A_CTRL, 32'd0);

        // unmapped / read-only writes ignored, byte strobes honoured
        wr(8'h04, 32'hDEAD_BEEF);
        rd_chk("unmapped_rd", 8'h04, 32'd0);
        wr(A_SENT, 32'd5);
        rd_chk("sent_ro", A_SENT, 32'd0);
        wr(A_GAP, 32'h1122_3344);
        wr(A_GAP, 32'hAABB_CCDD, 4'b0010);
        rd_chk("wstrb_merge", A_GAP, 32'h1122_CC44);
        wr(A_CTRL, 32'd1, 4'b0010);
        rd_chk("start_no_strb0", A_CTRL, 32'd0);
        chk("start_no_strb0_tvalid", 64'(tvalid), 64'd0);

        // back-to-back run: 10,15,20,25
        wr(A_BC, 32'd4); wr(A_GAP, 32'd0); wr(A_SV, 32'd10); wr(A_INC, 32'd5);
        tready = 1'b1;
        clrq();
        wr(A_CTRL, 32'd1);
        wait_beats(4, 50);
        chk("b2b_count", 64'(q_data.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_data.size()) begin
                chk("b2b_data", 64'(q_data[i]), 64'(10 + 5 * i));
                chk("b2b_cycle", 64'(q_cyc[i] - q_cyc[0]), 64'(i));
            end
        end
        tick(2);
        chk("b2b_tvalid_low", 64'(tvalid), 64'd0);
        rd_chk("b2b_ctrl_done", A_CTRL, 32'h2);
        rd_chk("b2b_sent", A_SENT, 32'd4);

        // gapped run: one beat every 3 cycles
        wr(A_GAP, 32'd2); wr(A_BC, 32'd3);
        clrq();
        wr(A_CTRL, 32'd1);
        wait_beats(3, 60);
        chk("gap_count", 64'(q_data.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < q_data.size()) begin
                chk("gap_data", 64'(q_data[i]), 64'(10 + 5 * i));
                chk("gap_cycle", 64'(q_cyc[i] - q_cyc[0]), 64'(3 * i));
            end
        end
        tick(4);
        rd_chk("gap_sent", A_SENT, 32'd3);

        // backpressure: hold tready low, data must not move
        tready = 1'b0;
        wr(A_BC, 32'd6); wr(A_GAP, 32'd0); wr(A_SV, 32'd100); wr(A_INC, 32'd1);
        clrq();
        wr(A_CTRL, 32'd1);
        ok = 0;
        for (int i = 0; i < 5; i++) begin
            if (tvalid && tdata == 32'd100) ok++;
            tick(1);
        end
        chk("stall_stable", 64'(ok), 64'd5);
        chk("stall_no_hs", 64'(q_data.size()), 64'd0);
        tready = 1'b1;
        tick(1);
        tready = 1'b0;
        chk("stall_one_hs", 64'(q_data.size()), 64'd1);
        chk("stall_advance", 64'(tdata), 64'd101);
        tready = 1'b1;
        wait_beats(6, 40);
        chk("stall_count", 64'(q_data.size()), 64'd6);
        if (q_data.size() == 6) chk("stall_last", 64'(q_data[5]), 64'd105);
        tick(2);
        rd_chk("stall_sent", A_SENT, 32'd6);

        // continuous run, STOP during a stall
        wr(A_BC, 32'd0); wr(A_SV, 32'd0);
        clrq();
        wr(A_CTRL, 32'd1);
        tick(3);
        tready = 1'b0;
        tick(1);
        wr(A_CTRL, 32'd2);
        tick(3);
        chk("stop_hold_tvalid", 64'(tvalid), 64'd1);
        rd_chk("stop_still_busy", A_CTRL, 32'h1);
        n0 = q_data.size();
        tready = 1'b1;
        tick(5);
        chk("stop_one_more", 64'(q_data.size()), 64'(n0 + 1));
        chk("stop_tvalid_low", 64'(tvalid), 64'd0);
        rd_chk("stop_done", A_CTRL, 32'h2);
        rd_chk("stop_sent", A_SENT, 32'(q_data.size()));

        // wrap modulo 2^32
        wr(A_SV, 32'hFFFF_FFFE); wr(A_INC, 32'd3); wr(A_BC, 32'd2);
        clrq();
        wr(A_CTRL, 32'd1);
        wait_beats(2, 20);
        chk("wrap_count", 64'(q_data.size()), 64'd2);
        if (q_data.size() == 2) begin
            chk("wrap_d0", 64'(q_data[0]), 64'hFFFF_FFFE);
            chk("wrap_d1", 64'(q_data[1]), 64'h0000_0001);
        end
        tick(2);
        wr(A_CTRL, 32'd4);
        rd_chk("clear_ctrl", A_CTRL, 32'd0);
        rd_chk("clear_sent", A_SENT, 32'd0);

        // mid-run START/CLEAR/BEAT_COUNT writes must not disturb the run
        wr(A_BC, 32'd4); wr(A_GAP, 32'd10); wr(A_SV, 32'd1); wr(A_INC, 32'd1);
        clrq();
        wr(A_CTRL, 32'd1);
        wr(A_CTRL, 32'd1);
        wr(A_CTRL, 32'd4);
        wr(A_BC, 32'd10);
        rd_chk("midrun_busy", A_CTRL, 32'h1);
        wait_beats(4, 100);
        tick(15);
        chk("midrun_count", 64'(q_data.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < q_data.size()) chk("midrun_data", 64'(q_data[i]), 64'(i + 1));
        rd_chk("midrun_sent", A_SENT, 32'd4);
        rd_chk("midrun_done", A_CTRL, 32'h2);
        rd_chk("midrun_bc_reg", A_BC, 32'd10);

        // reset while a beat is pending
        tready = 1'b0;
        wr(A_BC, 32'd0); wr(A_GAP, 32'd0);
        wr(A_CTRL, 32'd1);
        tick(2);
        chk("pre_rst_tvalid", 64'(tvalid), 64'd1);
        ap_rst = 1'b1;
        tick(1);
        chk("rst_mid_tvalid", 64'(tvalid), 64'd0);
        ap_rst = 1'b0;
        chk("rst_mid_tdata", 64'(tdata), 64'd0);
        rd_chk("rst_mid_inc",  A_INC,  32'd1);
        rd_chk("rst_mid_bc",   A_BC,   32'd0);
        rd_chk("rst_mid_gap",  A_GAP,  32'd0);
        rd_chk("rst_mid_sv",   A_SV,   32'd0);
        rd_chk("rst_mid_sent", A_SENT, 32'd0);
        rd_chk("rst_mid_ctrl", A_CTRL, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
